// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter giving four requesters turns on one shared FIFO write port.
// Define ARB_BURST_EN to let a single grant carry up to four writes.
module fifo_wr_arbiter #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic          fifo_full,
  output logic [3:0]    gnt,
  output logic [3:0]    accept,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_din,
  output logic [1:0]    owner,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e     state_q;
  logic [3:0] gnt_q;
  logic [1:0] owner_q;
  logic [1:0] ptr_q;
  logic       busy_q;

  logic [1:0] pick_c;
  logic       pick_vld_c;
  logic       wr_c;
  logic       end_grant_c;

  // Lowest offset from ptr with a pending request wins; scan high-to-low so it lands last.
  always_comb begin
    pick_c     = ptr_q;
    pick_vld_c = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        pick_c     = ptr_q + 2'(k);
        pick_vld_c = 1'b1;
      end
    end
  end

  assign accept     = gnt_q & req & {4{~fifo_full}};
  assign wr_c       = |accept;
  assign fifo_wr_en = wr_c;

  always_comb begin
    fifo_din = '0;
    case (gnt_q)
      4'b0001: fifo_din = din0;
      4'b0010: fifo_din = din1;
      4'b0100: fifo_din = din2;
      4'b1000: fifo_din = din3;
      default: fifo_din = '0;
    endcase
  end

`ifdef ARB_BURST_EN
  logic [1:0] burst_q;

  // Grant closes on the fourth write or when the owner walks away without writing.
  assign end_grant_c = (wr_c && (burst_q == 2'd3)) || (!wr_c && !req[owner_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= 2'd0;
    end else if (state_q == GRANT) begin
      if (end_grant_c) begin
        burst_q <= 2'd0;
      end else if (wr_c) begin
        burst_q <= burst_q + 2'd1;
      end
    end else begin
      burst_q <= 2'd0;
    end
  end
`else
  // Single write per grant; a dropped request abandons the grant.
  assign end_grant_c = wr_c || !req[owner_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_c) begin
            state_q <= GRANT;
            gnt_q   <= 4'(4'b0001 << pick_c);
            owner_q <= pick_c;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (end_grant_c) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            ptr_q   <= owner_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a per-cycle reference model pushes expected
// outputs, a negedge monitor pops and compares them and checks write safety and fairness.
module tb_fifo_wr_arbiter;
  localparam int unsigned DW = 8;
`ifdef ARB_BURST_EN
  localparam int MAXW = 4;
`else
  localparam int MAXW = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic          fifo_full;
  logic [DW-1:0] dv [4];
  logic [3:0]    gnt;
  logic [3:0]    accept;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic [1:0]    owner;
  logic          busy;

  fifo_wr_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din0(dv[0]), .din1(dv[1]), .din2(dv[2]), .din3(dv[3]),
    .fifo_full(fifo_full), .gnt(gnt), .accept(accept), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    owner;
    logic          busy;
    logic [3:0]    accept;
    logic          wr_en;
    logic [DW-1:0] din;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: who holds the port, where the search starts, writes in this grant.
  int holder     = -1;
  int ptr        = 0;
  int last_owner = 0;
  int writes     = 0;
  int din_mode   = 0;
  int cnt0       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  // Advance the model across one clock edge using the inputs held during the last cycle.
  task automatic model_edge();
    bit wr;
    if (rst) begin
      holder = -1; ptr = 0; last_owner = 0; writes = 0;
    end else if (holder < 0) begin
      if (req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(ptr + k) % 4]) begin
            holder = (ptr + k) % 4;
            break;
          end
        end
        last_owner = holder;
        writes = 0;
      end
    end else begin
      wr = req[holder] && !fifo_full;
      if (wr) begin
        writes++;
        if (holder == 0) cnt0++;
      end
      if ((wr && writes == MAXW) || (!wr && !req[holder])) begin
        ptr = (holder + 1) % 4;
        holder = -1;
        writes = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [3:0] rq, input bit full);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; req = rq; fifo_full = full;
    for (int i = 0; i < 4; i++) begin
      case (din_mode)
        0: dv[i] = DW'(8'hA0 + i);
        1: dv[i] = DW'($urandom);
        default: dv[i] = (i == 0) ? DW'(8'h10 + cnt0) : DW'(8'h50 + i);
      endcase
    end
    e.gnt    = (holder < 0) ? 4'b0000 : 4'(1 << holder);
    e.owner  = 2'(last_owner);
    e.busy   = (holder >= 0);
    e.accept = (holder >= 0 && req[holder] && !fifo_full) ? e.gnt : 4'b0000;
    e.wr_en  = (e.accept != 4'b0000);
    e.din    = (holder < 0) ? '0 : dv[holder];
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard compare, write-safety invariants, bounded wait per requester.
  logic [3:0] prev_req = 4'b0000;
  logic [3:0] prev_gnt = 4'b0000;
  int         waitc [4] = '{0, 0, 0, 0};
  bit         live = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      live = 1'b1;
      chk("gnt",        32'(gnt),        32'(e.gnt));
      chk("owner",      32'(owner),      32'(e.owner));
      chk("busy",       32'(busy),       32'(e.busy));
      chk("accept",     32'(accept),     32'(e.accept));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr_en));
      chk("fifo_din",   32'(fifo_din),   32'(e.din));
    end
    if (live) begin
      chk("accept_onehot0",  32'($countones(accept) <= 1), 32'd1);
      chk("no_write_full",   32'(fifo_wr_en && fifo_full), 32'd0);
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (i == int'(owner)) begin
            waitc[i] = 0;
          end else if (prev_req[i] && req[i]) begin
            waitc[i]++;
            chk("fair_wait", 32'(waitc[i] <= 3), 32'd1);
          end
        end
      end
      for (int i = 0; i < 4; i++) if (!req[i] || rst) waitc[i] = 0;
      prev_req = req;
      prev_gnt = gnt;
    end
  end

  initial begin
    rst = 1'b1; req = 4'b0000; fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = DW'(8'hA0 + i);

    cycle(1, 4'b0000, 0);
    cycle(1, 4'b0000, 0);
    cycle(0, 4'b0000, 0);

    // All four requesting: writes rotate 0,1,2,3,0 with one idle cycle between grants.
    for (int n = 0; n < 11; n++) cycle(0, 4'b1111, 0);
    cycle(0, 4'b0000, 0);
    cycle(0, 4'b0000, 0);

    // Owner 2 stalled by a full FIFO for five cycles, then writes once.
    cycle(1, 4'b0000, 0);
    cycle(0, 4'b0100, 0);
    for (int n = 0; n < 5; n++) cycle(0, 4'b0100, 1);
    cycle(0, 4'b0100, 0);
    cycle(0, 4'b0000, 0);
    cycle(0, 4'b0000, 0);

    // Abandoned grant to 1 moves the pointer to 2; next search wraps to 0.
    cycle(1, 4'b0000, 0);
    cycle(0, 4'b0010, 0);
    cycle(0, 4'b0000, 0);
    cycle(0, 4'b0000, 0);
    cycle(0, 4'b0011, 0);
    cycle(0, 4'b0011, 0);
    cycle(0, 4'b0011, 0);
    cycle(0, 4'b0011, 0);
    cycle(0, 4'b0000, 0);

    // Reset in the middle of a grant restarts arbitration at requester 0.
    cycle(1, 4'b0000, 0);
    cycle(0, 4'b0100, 0);
    cycle(0, 4'b0000, 0);
    cycle(0, 4'b1111, 0);
    cycle(1, 4'b1111, 0);
    for (int n = 0; n < 6; n++) cycle(0, 4'b1111, 0);

`ifdef ARB_BURST_EN
    // Single requester bursting with incrementing data.
    cycle(1, 4'b0000, 0);
    cnt0 = 0;
    din_mode = 2;
    for (int n = 0; n < 14; n++) cycle(0, 4'b0001, 0);
    cycle(0, 4'b0000, 0);
`endif

    din_mode = 1;
    cycle(1, 4'b0000, 0);
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom % 1000) == 0, 4'($urandom), ($urandom % 4) == 0);
    end
    cycle(0, 4'b0000, 0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
